// File: rtl/pwm_pkg.sv
// Shared constants for the multichannel PWM: mode encoding and packed-duty slicing.
package pwm_pkg;
    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    localparam int DEF_CHANNELS = 4;
    localparam int DEF_DUTY_W   = 8;
    localparam int DEF_CNT_W    = 19;

    // Low bit of channel k inside the packed duty bus.
    function automatic int duty_lsb(input int k, input int duty_w);
        return k * duty_w;
    endfunction
endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: threshold from active duty/period, compare against the shared
// counter, apply live polarity and register the output.
module pwm_channel_cmp #(
    parameter int DUTY_W = 8,
    parameter int CNT_W  = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic [CNT_W-1:0]  per_i,
    input  logic [DUTY_W-1:0] duty_i,
    input  logic              pol_i,
    output logic              pwm_o
);
    localparam int PW = CNT_W + DUTY_W;

    logic [PW-1:0] prod;
    logic [PW-1:0] thr;
    logic          raw;
    logic          pwm_d, pwm_q;

    // Full product width keeps duty*(P+1) exact before the shift.
    always_comb begin
        prod  = PW'(duty_i) * (PW'(per_i) + PW'(1));
        thr   = prod >> DUTY_W;
        raw   = (duty_i == '1) ? 1'b1 : (PW'(cnt_i) < thr);
        pwm_d = enable_i ? (raw ^ pol_i) : pol_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) pwm_q <= 1'b0;
        else      pwm_q <= pwm_d;
    end

    assign pwm_o = pwm_q;
endmodule

// File: rtl/pwm_multichannel.sv
// Multichannel PWM with a shared edge/centre-aligned period counter and
// double-buffered period/duty/mode that switch only at period boundaries.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int          CHANNELS       = DEF_CHANNELS,
    parameter int          DUTY_W         = DEF_DUTY_W,
    parameter int          CNT_W          = DEF_CNT_W,
    parameter int unsigned DEFAULT_PERIOD = 499_999
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [CNT_W-1:0]             period,
    input  logic [CHANNELS*DUTY_W-1:0]   duty,
    input  logic                         center_mode,
    input  logic [CHANNELS-1:0]          polarity,
    input  logic                         update,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         period_tick,
    output logic                         update_pending
);
    localparam logic [CNT_W-1:0] DEF_P = CNT_W'(DEFAULT_PERIOD);

    logic [CNT_W-1:0]           cnt_q, cnt_d, cnt_nxt;
    logic                       dir_q, dir_d, dir_nxt;
    logic [CNT_W-1:0]           per_q, per_d, per_s_q, per_s_d, per_in;
    logic [CHANNELS*DUTY_W-1:0] duty_q, duty_d, duty_s_q, duty_s_d;
    logic                       mode_q, mode_d, mode_s_q, mode_s_d;
    logic                       pend_q, pend_d, tick_q, tick_d;
    logic                       load;

    always_comb begin
        per_in  = (period == '0) ? CNT_W'(1) : period;
        cnt_nxt = cnt_q;
        dir_nxt = dir_q;
        // dir_q=1 means counting down (centre mode only).
        if (mode_q == MODE_EDGE) begin
            dir_nxt = 1'b0;
            cnt_nxt = (cnt_q == per_q) ? '0 : cnt_q + CNT_W'(1);
        end else if (!dir_q) begin
            if (cnt_q == per_q) begin
                cnt_nxt = per_q - CNT_W'(1);
                dir_nxt = (per_q != CNT_W'(1));
            end else begin
                cnt_nxt = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_nxt = cnt_q - CNT_W'(1);
            dir_nxt = (cnt_q != CNT_W'(1));
        end

        // Disabled behaves like a permanent boundary so pending values apply at once.
        load   = !enable || (cnt_nxt == '0);
        cnt_d  = enable ? cnt_nxt : '0;
        dir_d  = enable ? dir_nxt : 1'b0;
        tick_d = enable && (cnt_q == '0);

        per_s_d  = per_s_q;
        duty_s_d = duty_s_q;
        mode_s_d = mode_s_q;
        pend_d   = pend_q;
        if (update) begin
            per_s_d  = per_in;
            duty_s_d = duty;
            mode_s_d = center_mode;
            pend_d   = 1'b1;
        end

        per_d  = per_q;
        duty_d = duty_q;
        mode_d = mode_q;
        if (load) begin
            if (update) begin
                per_d  = per_in;
                duty_d = duty;
                mode_d = center_mode;
            end else if (pend_q) begin
                per_d  = per_s_q;
                duty_d = duty_s_q;
                mode_d = mode_s_q;
            end
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            dir_q    <= 1'b0;
            per_q    <= DEF_P;
            duty_q   <= '0;
            mode_q   <= MODE_EDGE;
            per_s_q  <= DEF_P;
            duty_s_q <= '0;
            mode_s_q <= MODE_EDGE;
            pend_q   <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
            per_q    <= per_d;
            duty_q   <= duty_d;
            mode_q   <= mode_d;
            per_s_q  <= per_s_d;
            duty_s_q <= duty_s_d;
            mode_s_q <= mode_s_d;
            pend_q   <= pend_d;
            tick_q   <= tick_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        pwm_channel_cmp #(
            .DUTY_W (DUTY_W),
            .CNT_W  (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .enable_i (enable),
            .cnt_i    (cnt_q),
            .per_i    (per_q),
            .duty_i   (duty_q[duty_lsb(g, DUTY_W) +: DUTY_W]),
            .pol_i    (polarity[g]),
            .pwm_o    (pwm_out[g])
        );
    end

    assign period_tick    = tick_q;
    assign update_pending = pend_q;
endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench: directed scenarios plus random stimulus against a
// period-sequence reference model.
module tb_pwm_multichannel;
    localparam int CH  = 4;
    localparam int DW  = 8;
    localparam int CW  = 19;
    localparam int DEF = 999;

    logic            clk = 1'b0;
    logic            rst, enable, center_mode, update;
    logic [CW-1:0]   period;
    logic [CH*DW-1:0] duty;
    logic [CH-1:0]   polarity;
    logic [CH-1:0]   pwm_out;
    logic            period_tick, update_pending;

    pwm_multichannel #(
        .CHANNELS(CH), .DUTY_W(DW), .CNT_W(CW), .DEFAULT_PERIOD(DEF)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period), .duty(duty),
        .center_mode(center_mode), .polarity(polarity), .update(update),
        .pwm_out(pwm_out), .period_tick(period_tick), .update_pending(update_pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: active/shadow sets and the list of counts left in this period.
    int m_per, s_per;
    int m_duty[CH];
    int s_duty[CH];
    bit m_mode, s_mode, m_pend;
    int seq[$];

    function automatic int san(input int p);
        return (p == 0) ? 1 : p;
    endfunction

    function automatic bit raw_lvl(input int d, input int p, input int c);
        if (d == 255) return 1'b1;
        return longint'(c) < ((longint'(d) * longint'(p + 1)) >> 8);
    endfunction

    task automatic build();
        seq.delete();
        for (int i = 0; i <= m_per; i++) seq.push_back(i);
        if (m_mode) for (int i = m_per - 1; i >= 1; i--) seq.push_back(i);
    endtask

    task automatic model_reset();
        m_per = DEF; s_per = DEF; m_mode = 0; s_mode = 0; m_pend = 0;
        for (int k = 0; k < CH; k++) begin m_duty[k] = 0; s_duty[k] = 0; end
        build();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [CH-1:0] e_pwm;
        logic e_tick;
        bit ld;
        int cur;
        if (!rst) begin
            model_reset();
            e_pwm = '0; e_tick = 1'b0;
        end else begin
            cur = seq[0];
            for (int k = 0; k < CH; k++)
                e_pwm[k] = enable ? (raw_lvl(m_duty[k], m_per, cur) ^ polarity[k]) : polarity[k];
            e_tick = enable && (cur == 0);
            ld = 0;
            if (!enable) ld = 1;
            else begin
                void'(seq.pop_front());
                if (seq.size() == 0) ld = 1;
            end
            if (ld) begin
                if (update) begin
                    m_per = san(int'(period)); m_mode = center_mode;
                    for (int k = 0; k < CH; k++) m_duty[k] = int'(duty[k*DW +: DW]);
                end else if (m_pend) begin
                    m_per = s_per; m_mode = s_mode;
                    for (int k = 0; k < CH; k++) m_duty[k] = s_duty[k];
                end
                m_pend = 0;
                build();
            end
            if (update) begin
                s_per = san(int'(period)); s_mode = center_mode;
                for (int k = 0; k < CH; k++) s_duty[k] = int'(duty[k*DW +: DW]);
                if (!ld) m_pend = 1;
            end
        end
        @(posedge clk);
        #1;
        chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
        chk("period_tick", 32'(period_tick), 32'(e_tick));
        chk("update_pending", 32'(update_pending), 32'(m_pend));
    endtask

    task automatic strobe();
        update = 1'b1; step(); update = 1'b0;
    endtask

    task automatic align();
        for (int i = 0; i < 3000 && seq[0] != 0; i++) step();
    endtask

    task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
        duty = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
    endtask

    int hi[CH];
    int ticks;

    task automatic run_count(input int n);
        ticks = 0;
        for (int k = 0; k < CH; k++) hi[k] = 0;
        for (int i = 0; i < n; i++) begin
            step();
            for (int k = 0; k < CH; k++) hi[k] += int'(pwm_out[k]);
            ticks += int'(period_tick);
        end
    endtask

    initial begin
        rst = 1'b0; enable = 1'b1; center_mode = 1'b0; update = 1'b0;
        period = '0; duty = '0; polarity = '0;
        model_reset();

        // Reset held, then one full default period with ch0 at duty 0.
        repeat (3) step();
        rst = 1'b1;
        run_count(DEF + 1);
        chk("default_ch0_high", 32'(hi[0]), 32'd0);

        // Edge mode P=9, loaded immediately via a disabled cycle.
        period = 9; set_duty(128, 255, 0, 64);
        enable = 1'b0; strobe(); enable = 1'b1;
        align();
        run_count(10);
        chk("edge_ch0_high", 32'(hi[0]), 32'd5);
        chk("edge_ch1_high", 32'(hi[1]), 32'd10);
        chk("edge_ch2_high", 32'(hi[2]), 32'd0);
        chk("edge_ch3_high", 32'(hi[3]), 32'd2);
        chk("edge_ticks", 32'(ticks), 32'd1);

        // Mid-period update at count 3.
        for (int i = 0; i < 20 && seq[0] != 3; i++) step();
        set_duty(64, 255, 0, 64);
        strobe();
        chk("mid_pending", 32'(update_pending), 32'd1);
        align();
        run_count(10);
        chk("mid_next_ch0_high", 32'(hi[0]), 32'd2);
        chk("mid_pending_clear", 32'(update_pending), 32'd0);

        // Update coincident with the boundary cycle.
        for (int i = 0; i < 20 && seq.size() != 1; i++) step();
        period = 4; set_duty(128, 255, 0, 64);
        strobe();
        run_count(5);
        chk("coinc_ch0_high", 32'(hi[0]), 32'd2);
        chk("coinc_ticks", 32'(ticks), 32'd1);

        // Centre mode P=8, T=4.
        period = 8; center_mode = 1'b1; set_duty(128, 0, 0, 0);
        strobe();
        align();
        run_count(16);
        chk("centre_ch0_high", 32'(hi[0]), 32'd7);
        chk("centre_ticks", 32'(ticks), 32'd1);

        // Polarity, enable and mid-period reset.
        period = 9; center_mode = 1'b0; set_duty(128, 255, 0, 64); polarity = 4'b0001;
        strobe();
        align();
        run_count(10);
        chk("pol_ch0_high", 32'(hi[0]), 32'd5);
        enable = 1'b0; step();
        chk("disable_out", 32'(pwm_out), 32'b0001);
        enable = 1'b1; step();
        chk("reenable_tick", 32'(period_tick), 32'd1);
        repeat (3) step();
        rst = 1'b0; step();
        chk("reset_mid_out", 32'(pwm_out), 32'd0);
        rst = 1'b1; polarity = '0;

        // Random phase.
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 7) == 0) begin
                period = CW'($urandom_range(0, 12));
                center_mode = 1'($urandom_range(0, 1));
                for (int k = 0; k < CH; k++) begin
                    case ($urandom_range(0, 3))
                        0: duty[k*DW +: DW] = 8'd0;
                        1: duty[k*DW +: DW] = 8'd255;
                        default: duty[k*DW +: DW] = 8'($urandom_range(0, 255));
                    endcase
                end
                update = 1'b1;
            end
            enable = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 29) == 0) polarity = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 199) != 0);
            step();
            update = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pwm_multichannel.md
Name: pwm_multichannel

Overview:
Parametrised successor to the team's single-channel fixed 100 Hz PWM. It provides CHANNELS independent PWM outputs that share one period counter. The period is programmable at runtime, and each channel has its own duty and output polarity. Edge-aligned or centre-aligned counting is selectable. Duty, period and mode are double-buffered and take effect only at a period boundary, so outputs never glitch. It sits between the control/register logic and the motor/LED/servo drivers.

Parameters:
CHANNELS, 4, number of PWM outputs
DUTY_W, 8, duty resolution per channel in bits
CNT_W, 19, period counter width
DEFAULT_PERIOD, 499_999, active period value after reset (100 Hz edge-aligned at 50 MHz)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-low (asserted when 0, sampled on rising clk)
enable  input  1  1 = run; 0 = counter held at 0 and outputs idle
period  input  CNT_W  requested terminal count P; period is P+1 cycles (edge) or 2P cycles (centre)
duty  input  CHANNELS*DUTY_W  packed per-channel duty; channel k occupies bits [k*DUTY_W +: DUTY_W]
center_mode  input  1  requested mode: 0 = edge-aligned, 1 = centre-aligned
polarity  input  CHANNELS  per-channel inversion, applied live (not buffered)
update  input  1  single-cycle strobe; captures period/duty/center_mode into the shadow set
pwm_out  output  CHANNELS  registered PWM outputs
period_tick  output  1  one-cycle pulse at each period start
update_pending  output  1  1 while captured shadow values await a boundary

Behaviour:
Reset (rst=0): all of the following are cleared or set as listed. Outputs hold these values while rst=0.
- counter=0, direction=up.
- active period=DEFAULT_PERIOD, active duties=0, active mode=edge.
- shadow registers equal the active set; pending=0.
- pwm_out=0 (all channels, regardless of polarity); period_tick=0; update_pending=0.

Shadowing:
- update=1 copies the inputs into the shadow registers and sets pending.
- At a boundary with pending=1, the active set loads from the shadow set and pending clears.
- If update and a boundary coincide, the active set loads directly from the inputs that cycle, and pending ends at 0.
- An update issued while pending=1 overwrites the shadow set; the last strobe wins.

Period-value rules:
- A period value of 0 is treated as 1.
- The active period is only ever changed at a boundary.

Boundary definition:
- A boundary is the cycle in which the counter will next equal 0 at period start.
- Active values loaded at a boundary govern the cycle in which the counter equals 0.

Edge mode:
- Counter runs 0..P, then wraps to 0.

Centre mode:
- Counter counts up 0..P, then down P-1..1, then returns to 0 (2P cycles per period).
- A change of mode takes effect only at a boundary; the counter restarts at 0 going up.

Threshold (per channel k):
- T_k = (duty_k * (P+1)) >> DUTY_W, computed at CNT_W+DUTY_W bits with no truncation before the shift.
- duty_k = all-ones forces the raw output to 1 for the whole period; duty_k = 0 gives a raw output of 0.

Output:
- raw_k = (counter < T_k).
- pwm_out[k] is registered as raw_k XOR polarity[k].
- Latency is 1 cycle from the counter value to pwm_out.

period_tick:
- Asserted in the cycle after the counter equals 0 (aligned with pwm_out of the first cycle of each period).

enable=0:
- Counter is forced to 0, direction up, period_tick=0.
- pwm_out[k] = polarity[k], i.e. the inactive level.
- If pending=1, the shadow set loads immediately.
- On the first enabled cycle the counter is 0 and counts from there.

Reset mid-period:
- Applies the reset values on the next clk edge; the shadow contents are discarded.

Decomposition:
- Package pwm_pkg: mode encoding constants (MODE_EDGE=0, MODE_CENTER=1) and the packed-duty slice helper width constants.
- Sub-module pwm_channel_cmp (one instance per channel): threshold multiply/shift, full-scale override, compare, polarity and output register.
- Top level owns the counter, direction, shadow/active registers, pending flag and period_tick.

Test Plan:
All scenarios use CHANNELS=4, DUTY_W=8.
1. Reset: hold rst=0 for 3 cycles with enable=1 -> pwm_out=4'b0000, period_tick=0, update_pending=0. After release, with no update, ch0 stays low (duty 0) over a full 500000-cycle period.
2. Edge mode: update with P=9 and duties ch0=128, ch1=255, ch2=0, ch3=64 -> period 10 cycles.
   - ch0 high 5 of 10 (T=5); ch1 always high; ch2 always low; ch3 high 2 (T=2).
   - period_tick every 10 cycles.
3. Mid-period update: change ch0 from 128 to 64 while counter=3 -> update_pending=1, and the current period completes with 5 high cycles. The next period has 2 high cycles; pending clears at the boundary.
4. Coincident update: strobe update in the boundary cycle (counter=9, P=9) with P=4 and ch0=128 -> the immediately following period is 5 cycles with ch0 high 2 (T=2); update_pending never asserts.
5. Centre mode: P=8, ch0=128, T=4 -> period 16 cycles.
   - Counter runs 0..8 up, then 7..1 down.
   - ch0 high on counts 0-3 up and 3-1 down: 7 contiguous-around-boundary cycles per 16.
6. Polarity and enable: polarity=4'b0001 with scenario 2 values -> ch0 is low 5 and high 5 cycles.
   - Dropping enable -> pwm_out=4'b0001 next cycle, counter 0.
   - Re-enabling -> restarts at count 0 with period_tick.
   - Asserting rst=0 mid-period -> pwm_out=0000 next edge.
